// File: rtl/popcount_accum.sv
// Packet popcount accumulator: sums per-byte counts over a packet and holds
// one saturated result (total, beats, overflow, illegal-count flag) for downstream.
module popcount_accum #(
   parameter int ACC_WIDTH  = 16,
   parameter int BEAT_WIDTH = 12
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_count,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_total,
   output logic [BEAT_WIDTH-1:0] out_beats,
   output logic                  out_overflow,
   output logic                  out_err
);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t                state_reg, state_next;
   logic [ACC_WIDTH-1:0]  acc_reg;
   logic [BEAT_WIDTH-1:0] beats_reg;
   logic                  ovf_reg;
   logic                  err_reg;

   logic                  accept;
   logic [ACC_WIDTH:0]    acc_sum;
   logic [BEAT_WIDTH:0]   beat_sum;
   logic [ACC_WIDTH-1:0]  acc_sat;
   logic [BEAT_WIDTH-1:0] beat_sat;
   logic                  ovf_new;
   logic                  err_new;

   // One extra bit of headroom; the carry-out is the clip indication.
   assign acc_sum  = {1'b0, acc_reg} + {{(ACC_WIDTH - 3){1'b0}}, in_count};
   assign beat_sum = {1'b0, beats_reg} + {{BEAT_WIDTH{1'b0}}, 1'b1};
   assign acc_sat  = acc_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];
   assign beat_sat = beat_sum[BEAT_WIDTH] ? {BEAT_WIDTH{1'b1}} : beat_sum[BEAT_WIDTH-1:0];
   assign ovf_new  = ovf_reg | acc_sum[ACC_WIDTH] | beat_sum[BEAT_WIDTH];
   assign err_new  = err_reg | (in_count > 4'd8);
   assign accept   = in_valid & in_ready;

   // Handshake outputs depend on the state register only.
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && in_last) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = ACCUM;
            end
         end
         default: state_next = ACCUM;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg    <= ACCUM;
         acc_reg      <= '0;
         beats_reg    <= '0;
         ovf_reg      <= 1'b0;
         err_reg      <= 1'b0;
         out_total    <= '0;
         out_beats    <= '0;
         out_overflow <= 1'b0;
         out_err      <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            if (in_last) begin
               out_total    <= acc_sat;
               out_beats    <= beat_sat;
               out_overflow <= ovf_new;
               out_err      <= err_new;
               acc_reg      <= '0;
               beats_reg    <= '0;
               ovf_reg      <= 1'b0;
               err_reg      <= 1'b0;
            end else begin
               acc_reg   <= acc_sat;
               beats_reg <= beat_sat;
               ovf_reg   <= ovf_new;
               err_reg   <= err_new;
            end
         end
      end
   end

endmodule

// File: tb/tb_popcount_accum.sv
// Self-checking bench: a default-width and a narrow popcount_accum share the same
// stimulus; each packet result is compared against a per-packet arithmetic model.
module tb_popcount_accum;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_count;
   logic        in_last;
   logic        out_ready;

   logic        in_ready, out_valid, out_overflow, out_err;
   logic [15:0] out_total;
   logic [11:0] out_beats;

   logic        s_in_ready, s_out_valid, s_out_overflow, s_out_err;
   logic [3:0]  s_out_total;
   logic [2:0]  s_out_beats;

   int checks = 0;
   int passed = 0;

   popcount_accum #(.ACC_WIDTH(16), .BEAT_WIDTH(12)) dut (
      .CLK(clk), .RESET(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_count(in_count), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_total(out_total), .out_beats(out_beats),
      .out_overflow(out_overflow), .out_err(out_err));

   // Narrow instance so total and beat saturation are reachable quickly.
   popcount_accum #(.ACC_WIDTH(4), .BEAT_WIDTH(3)) dut_s (
      .CLK(clk), .RESET(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_count(in_count), .in_last(in_last), .out_valid(s_out_valid),
      .out_ready(out_ready), .out_total(s_out_total), .out_beats(s_out_beats),
      .out_overflow(s_out_overflow), .out_err(s_out_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic void model(input int cnts[$], input int aw, input int bw,
                                 output longint tot, output longint bts,
                                 output bit ovf, output bit err);
      longint sum = 0;
      longint maxa = (longint'(1) << aw) - 1;
      longint maxb = (longint'(1) << bw) - 1;
      err = 1'b0;
      foreach (cnts[k]) begin
         sum += cnts[k];
         if (cnts[k] > 8) err = 1'b1;
      end
      tot = (sum > maxa) ? maxa : sum;
      bts = (cnts.size() > maxb) ? maxb : cnts.size();
      ovf = (sum > maxa) || (cnts.size() > maxb);
   endfunction

   task automatic check_reset_state(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_total"}, out_total, 0);
      check({tag, "_beats"}, out_beats, 0);
      check({tag, "_ovf"}, out_overflow, 0);
      check({tag, "_err"}, out_err, 0);
      check({tag, "_s_out_valid"}, s_out_valid, 0);
      check({tag, "_s_total"}, s_out_total, 0);
      check({tag, "_s_beats"}, s_out_beats, 0);
   endtask

   // hold_n: cycles of out_ready=0 before releasing; -1 random; -2 stay in HOLD.
   // next_first >= 0 presents that count with in_valid=1 while the result is held.
   task automatic send_pkt(input int cnts[$], input int stall_pct, input int hold_n,
                           input int next_first, output int acc_cyc, output int hold_cyc);
      longint et, eb, st, sb;
      bit eo, ee, so, se, go, rdy;
      int i = 0;
      model(cnts, 16, 12, et, eb, eo, ee);
      model(cnts, 4, 3, st, sb, so, se);
      acc_cyc = 0;
      hold_cyc = 0;
      while (i < cnts.size()) begin
         check("accum_in_ready", in_ready, 1);
         check("accum_out_valid", out_valid, 0);
         in_valid  = ($urandom_range(99) >= stall_pct);
         in_count  = 4'(cnts[i]);
         in_last   = (i == cnts.size() - 1);
         out_ready = 1'($urandom_range(1));
         go = in_valid;
         tick();
         acc_cyc++;
         if (go) i++;
         if (acc_cyc > 5000) begin
            check("accum_timeout", acc_cyc, 0);
            return;
         end
      end
      in_valid = (next_first >= 0);
      in_count = (next_first >= 0) ? 4'(next_first) : 4'($urandom_range(15));
      in_last  = (next_first >= 0) ? 1'b0 : 1'($urandom_range(1));
      for (int c = 0; c < 3000; c++) begin
         check("hold_out_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("total", out_total, et);
         check("beats", out_beats, eb);
         check("ovf", out_overflow, eo);
         check("err", out_err, ee);
         check("s_total", s_out_total, st);
         check("s_beats", s_out_beats, sb);
         check("s_ovf", s_out_overflow, so);
         check("s_err", s_out_err, se);
         if (hold_n == -2) return;
         rdy = (hold_n == -1) ? 1'($urandom_range(1)) : (c >= hold_n);
         out_ready = rdy;
         tick();
         hold_cyc++;
         if (rdy) break;
      end
      out_ready = 1'b0;
      if (hold_cyc >= 3000) check("hold_timeout", hold_cyc, 0);
   endtask

   initial begin
      int pk[$];
      int ac, hc, n;
      rst = 1'b1; in_valid = 1'b0; in_count = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      check_reset_state("reset");

      // Basic packet; result visible right after the last accept, one HOLD cycle.
      pk = {3, 8, 0, 5};
      send_pkt(pk, 0, 0, -1, ac, hc);
      check("basic_accept_cycles", ac, 4);
      check("basic_in_ready_low_cycles", hc, 1);

      // Backpressure with the next packet's first beat waiting.
      pk = {7};
      send_pkt(pk, 0, 5, 2, ac, hc);
      check("bp_hold_cycles", hc, 6);
      pk = {2, 3};
      send_pkt(pk, 0, 0, -1, ac, hc);
      check("bp_next_accept_cycles", ac, 2);

      // Saturation (narrow instance) and flag clearing.
      pk = {8, 8, 8};
      send_pkt(pk, 0, 0, -1, ac, hc);
      pk = {1, 1};
      send_pkt(pk, 0, 0, -1, ac, hc);

      // Illegal count, then clean packet.
      pk = {12, 2};
      send_pkt(pk, 0, 0, -1, ac, hc);
      pk = {4};
      send_pkt(pk, 0, 0, -1, ac, hc);

      // Reset mid-packet, asserted together with a valid beat.
      in_valid = 1'b1; in_count = 4'd5; in_last = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      check_reset_state("rst_mid");
      pk = {1};
      send_pkt(pk, 0, 0, -1, ac, hc);

      // Reset while holding a result, with out_ready high on the same edge.
      pk = {9, 3};
      send_pkt(pk, 0, -2, -1, ac, hc);
      rst = 1'b1; out_ready = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b0;
      check_reset_state("rst_hold");

      // Random stall soak.
      for (int p = 0; p < 1000; p++) begin
         pk = {};
         n = $urandom_range(20, 1);
         for (int b = 0; b < n; b++)
            pk.push_back(($urandom_range(9) == 0) ? $urandom_range(15, 9) : $urandom_range(8));
         send_pkt(pk, 50, -1, -1, ac, hc);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/popcount_accum.md
# popcount_accum

Streaming accumulator placed directly downstream of the 8-bit popcount stage. It takes one 4-bit per-byte population count per beat over a valid/ready handshake and sums the counts across a packet delimited by `in_last`. It then presents the packet total, the beat count and status flags on an output handshake. Results go to the statistics/CSR layer; the block holds one finished result at a time.

## Interface
- `ACC_WIDTH`, default 16: width of the total accumulator and `out_total`. Must be ≥ 4.
- `BEAT_WIDTH`, default 12: width of the beat counter and `out_beats`. Must be ≥ 1.

- `CLK`  in  1  clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_count`  in  4  popcount of one byte; legal range 0..8.
- `in_last`  in  1  marks the final beat of a packet.
- `out_valid`  out  1  packet result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_total`  out  ACC_WIDTH  sum of `in_count` over the packet, saturating.
- `out_beats`  out  BEAT_WIDTH  beats in the packet, saturating.
- `out_overflow`  out  1  `out_total` or `out_beats` saturated during the packet.
- `out_err`  out  1  at least one beat in the packet had `in_count` > 8.

## Operation
- FSM has two states: ACCUM (reset state) and HOLD.
- ACCUM state:
  - `in_ready`=1 and `out_valid`=0.
  - A beat is accepted when `in_valid & in_ready` is true at a rising edge.
- On an accepted non-last beat:
  - `acc <= sat(acc + in_count)`.
  - `beats <= sat(beats + 1)`.
  - `ovf` is set sticky if either sum clips.
  - `err` is set sticky if `in_count` > 8. The value is still added as-is.
- On an accepted last beat:
  - The same arithmetic is applied, but the result goes into the output registers (`out_total`, `out_beats`, `out_overflow`, `out_err`).
  - Internal `acc`, `beats`, `ovf` and `err` clear to 0.
  - FSM goes to HOLD.
- HOLD state:
  - `in_ready`=0 and `out_valid`=1.
  - Output registers stay stable until `out_valid & out_ready`; on that edge the FSM returns to ACCUM.
- Saturation:
  - `sat(x)` = min(x, 2^W−1), with W = ACC_WIDTH or BEAT_WIDTH as appropriate.
  - Addition is done at W+1 bits, then clipped. Nothing wraps.
- Single-beat packet (`in_last` on the first beat): `out_beats`=1 and `out_total`=`in_count`.
- `in_count`, `in_last` and `out_ready` are ignored on edges where their handshake does not fire.
- Reset:
  - Values after reset: FSM=ACCUM, `in_ready`=1, `out_valid`=0, `out_total`=0, `out_beats`=0, `out_overflow`=0, `out_err`=0, and internal acc, beats, ovf, err all 0.
  - Reset has priority over any handshake on the same edge.
  - Reset mid-packet discards the partial packet.
  - Reset in HOLD discards the pending result.

## Timing
- `in_ready` and `out_valid` are decoded from the FSM state register only. There is no combinational path from `in_valid` or `out_ready` to either.
- Latency: when the last beat is accepted at edge N, `out_valid`=1 is visible after edge N, i.e. in cycle N+1.
- Minimum HOLD time is 1 cycle if `out_ready`=1. The first beat of the next packet can then be accepted at edge N+2.
- Throughput: one beat per cycle inside a packet, plus one bubble per packet.
- `out_ready` held high while in ACCUM has no effect.
- Upstream must hold `in_valid`/`in_count`/`in_last` stable while `in_ready`=0. The block does not check this.

## Test plan
- Reset, then packet counts 3,8,0,5 with `in_last` on the 4th beat and `out_ready`=1:
  - `out_valid` rises in the cycle after the 4th accept.
  - `out_total`=16, `out_beats`=4, `out_overflow`=0, `out_err`=0.
  - `in_ready`=0 for exactly 1 cycle.
- Backpressure: single-beat packet `in_count`=7, `out_ready`=0 for 5 cycles, `in_valid` kept high with the next packet:
  - `out_valid` stays 1 and `in_ready` stays 0; `out_total`=7 holds for 5 cycles.
  - After `out_ready`=1, the next beat is accepted on the following edge.
- Saturation with ACC_WIDTH=4: three beats of 8 then `in_last`:
  - `out_total`=15, `out_overflow`=1.
  - The following packet 1,1 gives `out_total`=2, `out_overflow`=0 (flag cleared).
- Illegal value: packet 12,2:
  - `out_total`=14, `out_err`=1.
  - The next packet 4 gives `out_err`=0.
- Reset mid-operation:
  - Assert RESET after 2 of 4 beats (counts 5,5). Then packet 1 gives `out_total`=1, `out_beats`=1.
  - Assert RESET in HOLD: `out_valid`=0 on the next cycle and all outputs are 0.
- Random stall soak: random `in_valid`/`out_ready` at 50 %, 1000 packets of 1–20 beats. Every result matches a reference-model sum, and no result is lost or duplicated.
